spi_sample_fifo: RTL and testbench

//  Parametrised circular-buffer FIFO between the SPI master receiver and the readout/display logic.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_fifo_ctrl.sv | 93 +++++++++
 rtl/spi_sample_fifo.sv | 71 +++++++
 tb/tb_spi_sample_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI sample defaults for the receiver, FIFO and readout logic.
// Keeps sample width and FIFO sizing consistent across the slice.
package spi_pkg;

   localparam int SPI_SAMPLE_W   = 16;
   localparam int SPI_FIFO_DEPTH = 8;
   localparam int SPI_AF_THRESH  = 6;

endpackage

// File: rtl/spi_fifo_ctrl.sv
// FIFO control: pointers, level counter, registered flags, sticky bits.
// Optional drop counter when SPI_SAMPLE_FIFO_STATS_EN is defined.
module spi_fifo_ctrl
   import spi_pkg::*;
#(
   parameter int DEPTH     = SPI_FIFO_DEPTH,
   parameter int AF_THRESH = SPI_AF_THRESH,
   localparam int AW       = $clog2(DEPTH),
   localparam int LW       = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic          push,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic          empty,
   output logic          full,
   output logic          almost_full,
   output logic [LW-1:0] level,
   output logic          overflow,
   output logic          underflow
`ifdef SPI_SAMPLE_FIFO_STATS_EN
   ,
   output logic [15:0]   drop_count
`endif
);

   logic          pop;
   logic [LW-1:0] lvl_nxt;

   // Accept decisions and next occupancy; a pop frees room for a push when full
   always_comb begin
      push    = wr_en && (!full || rd_en) && !flush;
      pop     = rd_en && !empty && !flush;
      lvl_nxt = level;
      if (push && !pop)
         lvl_nxt = level + LW'(1);
      else if (pop && !push)
         lvl_nxt = level - LW'(1);
   end

   // Pointers, level and flags move together on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level       <= lvl_nxt;
         empty       <= (lvl_nxt == '0);
         full        <= (lvl_nxt == LW'(DEPTH));
         almost_full <= (lvl_nxt >= LW'(AF_THRESH));
         if (wr_en && !push)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end

`ifdef SPI_SAMPLE_FIFO_STATS_EN
   // Saturating count of rejected pushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count <= '0;
      else if (flush)
         drop_count <= '0;
      else if (wr_en && !push && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end
`endif

endmodule

// File: rtl/spi_sample_fifo.sv
// FWFT sample FIFO between SPI receiver and readout: storage and read mux.
// Define SPI_SAMPLE_FIFO_STATS_EN to add the drop_count output.
module spi_sample_fifo
   import spi_pkg::*;
#(
   parameter int WIDTH     = SPI_SAMPLE_W,
   parameter int DEPTH     = SPI_FIFO_DEPTH,
   parameter int AF_THRESH = SPI_AF_THRESH,
   localparam int AW       = $clog2(DEPTH),
   localparam int LW       = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic [LW-1:0]    level,
   output logic             overflow,
   output logic             underflow
`ifdef SPI_SAMPLE_FIFO_STATS_EN
   ,
   output logic [15:0]      drop_count
`endif
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;

   spi_fifo_ctrl #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
   ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .push        (push),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .level       (level),
      .overflow    (overflow),
      .underflow   (underflow)
`ifdef SPI_SAMPLE_FIFO_STATS_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   // Sample storage; contents are left alone by reset, pointers make them stale
   always_ff @(posedge clk) begin
      if (push && rst_n)
         mem[wr_ptr] <= wr_data;
   end

   // Oldest entry falls through; zero while nothing is held
   always_comb begin
      rd_data = empty ? '0 : mem[rd_ptr];
   end

endmodule

// File: tb/tb_spi_sample_fifo.sv
// Self-checking bench for spi_sample_fifo: queue model plus directed vectors.
// Covers fill, drain, overflow, wrap, empty push+pop, flush and async reset.
module tb_spi_sample_fifo;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        empty;
   logic        full;
   logic        almost_full;
   logic [3:0]  level;
   logic        overflow;
   logic        underflow;
`ifdef SPI_SAMPLE_FIFO_STATS_EN
   logic [15:0] drop_count;
`endif

   spi_sample_fifo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .level       (level),
      .overflow    (overflow),
      .underflow   (underflow)
`ifdef SPI_SAMPLE_FIFO_STATS_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [15:0] q[$];
   bit          m_ov;
   bit          m_un;
   int          m_drop;
   bit          cmp_en;
   logic [15:0] exp_rd;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_ov   = 1'b0;
      m_un   = 1'b0;
      m_drop = 0;
   endtask

   task automatic model_step(input logic w, input logic [15:0] d,
                             input logic r, input logic f);
      bit was_full;
      bit was_empty;
      bit take;
      bit give;
      if (f) begin
         model_clear();
         return;
      end
      was_full  = (q.size() == 8);
      was_empty = (q.size() == 0);
      give = r && !was_empty;
      take = w && (!was_full || r);
      if (w && !take) begin
         m_ov = 1'b1;
         if (m_drop < 65535)
            m_drop++;
      end
      if (r && was_empty)
         m_un = 1'b1;
      if (give)
         void'(q.pop_front());
      if (take)
         q.push_back(d);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         exp_rd = (q.size() > 0) ? q[0] : 16'h0000;
         chk("rd_data", 32'(rd_data), 32'(exp_rd));
         chk("level", 32'(level), 32'(q.size()));
         chk("empty", 32'(empty), 32'(q.size() == 0));
         chk("full", 32'(full), 32'(q.size() == 8));
         chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
         chk("overflow", 32'(overflow), 32'(m_ov));
         chk("underflow", 32'(underflow), 32'(m_un));
`ifdef SPI_SAMPLE_FIFO_STATS_EN
         chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
      end
   end

   task automatic cyc(input logic w, input logic [15:0] d,
                      input logic r, input logic f);
      @(negedge clk);
      #1;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      flush   = f;
      @(posedge clk);
      model_step(w, d, r, f);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".level"}, 32'(level), 32'd0);
      chk({tag, ".empty"}, 32'(empty), 32'd1);
      chk({tag, ".full"}, 32'(full), 32'd0);
      chk({tag, ".af"}, 32'(almost_full), 32'd0);
      chk({tag, ".ovf"}, 32'(overflow), 32'd0);
      chk({tag, ".unf"}, 32'(underflow), 32'd0);
      chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      cmp_en  = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 16'(i * 257), 1'b0, 1'b0);
         if (i == 5)
            chk("t1.af_at5", 32'(almost_full), 32'd0);
         if (i == 6)
            chk("t1.af_at6", 32'(almost_full), 32'd1);
      end
      chk("t1.full", 32'(full), 32'd1);
      chk("t1.level", 32'(level), 32'd8);
      chk("t1.rd_data", 32'(rd_data), 32'h0101);

      for (int i = 1; i <= 8; i++) begin
         chk("t2.seq", 32'(rd_data), 32'(i * 257));
         cyc(1'b0, 16'h0, 1'b1, 1'b0);
      end
      chk("t2.empty", 32'(empty), 32'd1);
      chk("t2.rd_data", 32'(rd_data), 32'd0);

      for (int i = 1; i <= 8; i++)
         cyc(1'b1, 16'(i * 257), 1'b0, 1'b0);
      cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
      chk("t3.ovf", 32'(overflow), 32'd1);
      chk("t3.level", 32'(level), 32'd8);
      chk("t3.rd_data", 32'(rd_data), 32'h0101);
`ifdef SPI_SAMPLE_FIFO_STATS_EN
      chk("t3.drops", 32'(drop_count), 32'd1);
`endif

      cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
      chk("t4.level", 32'(level), 32'd8);
      chk("t4.rd_data", 32'(rd_data), 32'h0202);
      for (int i = 0; i < 7; i++)
         cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("t4.last", 32'(rd_data), 32'hBEEF);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("t4.empty", 32'(empty), 32'd1);

      cyc(1'b1, 16'h1234, 1'b1, 1'b0);
      chk("t5.level", 32'(level), 32'd1);
      chk("t5.unf", 32'(underflow), 32'd1);
      chk("t5.rd_data", 32'(rd_data), 32'h1234);

      for (int i = 0; i < 4; i++)
         cyc(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
      chk("t6.level5", 32'(level), 32'd5);
      cyc(1'b1, 16'h5555, 1'b1, 1'b1);
      check_reset_vals("t6.flush");

      for (int i = 0; i < 3; i++)
         cyc(1'b1, 16'(16'hC000 + i), 1'b0, 1'b0);
      chk("t6.level3", 32'(level), 32'd3);
      @(negedge clk);
      #1;
      wr_en   = 1'b1;
      wr_data = 16'h9999;
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_reset_vals("t6.async");
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      check_reset_vals("t6.rst");
      rst_n = 1'b1;

      cyc(1'b1, 16'h7777, 1'b0, 1'b0);
      chk("t6.post", 32'(rd_data), 32'h7777);
      chk("t6.postlvl", 32'(level), 32'd1);

      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
